ddr4_cmd_sequencer: RTL and testbench

Closed-page DDR4 command sequencer that sits directly upstream of the dimm model and drives its command/address pins. It accepts one read or write request at a time over a valid/ready handshake. For each request it issues ACT, waits tRCD, issues RD or WR, and times the data window. It then closes the bank with PRE and waits tRP before returning to IDLE. It also produces the DQ output-enable and read-capture strobes that the data path uses around the dimm.

---
 rtl/ddr4_cmd_sequencer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_ddr4_cmd_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ddr4_cmd_sequencer.sv
// ddr4_cmd_sequencer
// Closed-page DDR4 command sequencer: ACT -> RD/WR -> data window -> PRE -> tRP
// for one request at a time. Every output is registered and decoded from the
// next state and next transaction cycle, so each output shows the value that
// belongs to the cycle in which it is visible.
// Build option: define AUTO_PRECHARGE_EN to fold the precharge into the RD/WR
// command (A10=1). The PRE slot then stays a NOP and the total latency is unchanged.
module ddr4_cmd_sequencer #(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int BL        = 8,
    parameter int TINIT     = 5,
    parameter int TRCD      = 15,
    parameter int TCL       = 15,
    parameter int TCWL      = 12,
    parameter int TWR       = 12,
    parameter int TRAS      = 32,
    parameter int TRP       = 15
) (
    input  logic                 ck_t,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [BGWIDTH-1:0]   req_bg,
    input  logic [BAWIDTH-1:0]   req_ba,
    input  logic [ADDRWIDTH-1:0] req_row,
    input  logic [COLWIDTH-1:0]  req_col,
    output logic                 cke,
    output logic                 cs_n,
    output logic                 act_n,
    output logic [ADDRWIDTH-1:0] A,
    output logic [BGWIDTH-1:0]   bg,
    output logic [BAWIDTH-1:0]   ba,
    output logic                 odt,
    output logic                 dq_oe,
    output logic                 rd_valid,
    output logic                 busy
);

    // Transaction cycle numbers, with the ACT cycle as cycle 0
    localparam int RD_FIRST_I = TRCD + TCL;
    localparam int RD_LAST_I  = TRCD + TCL + BL - 1;
    localparam int WR_FIRST_I = TRCD + TCWL;
    localparam int WR_LAST_I  = TRCD + TCWL + BL - 1;
    localparam int PRE_RD_I   = (TRAS > TRCD + TCL + BL) ? TRAS : TRCD + TCL + BL;
    localparam int PRE_WR_I   = (TRAS > TRCD + TCWL + BL + TWR) ? TRAS : TRCD + TCWL + BL + TWR;
    localparam int END_RD_I   = PRE_RD_I + TRP;
    localparam int END_WR_I   = PRE_WR_I + TRP;
    localparam int END_MAX_I  = (END_RD_I > END_WR_I) ? END_RD_I : END_WR_I;
    localparam int CNT_MAX_I  = (END_MAX_I > TINIT) ? END_MAX_I : TINIT;
    localparam int CNT_W      = $clog2(CNT_MAX_I + 1);

    localparam logic [CNT_W-1:0] C_TINIT    = CNT_W'(TINIT);
    localparam logic [CNT_W-1:0] C_TRCD     = CNT_W'(TRCD);
    localparam logic [CNT_W-1:0] C_RD_FIRST = CNT_W'(RD_FIRST_I);
    localparam logic [CNT_W-1:0] C_RD_LAST  = CNT_W'(RD_LAST_I);
    localparam logic [CNT_W-1:0] C_WR_FIRST = CNT_W'(WR_FIRST_I);
    localparam logic [CNT_W-1:0] C_WR_LAST  = CNT_W'(WR_LAST_I);
    localparam logic [CNT_W-1:0] C_PRE_RD   = CNT_W'(PRE_RD_I);
    localparam logic [CNT_W-1:0] C_PRE_WR   = CNT_W'(PRE_WR_I);
    localparam logic [CNT_W-1:0] C_END_RD   = CNT_W'(END_RD_I);
    localparam logic [CNT_W-1:0] C_END_WR   = CNT_W'(END_WR_I);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(CNT_MAX_I);

`ifdef AUTO_PRECHARGE_EN
    localparam logic AUTO_PRE = 1'b1;
`else
    localparam logic AUTO_PRE = 1'b0;
`endif

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_ACT,
        ST_TRCD,
        ST_CMD,
        ST_DATA,
        ST_RECOVER,
        ST_PRE,
        ST_TRP
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt, cnt_inc;
    logic                 accept;

    // Request captured at acceptance; later changes on req_* are ignored
    logic                 wr_q;
    logic [BGWIDTH-1:0]   bg_q;
    logic [BAWIDTH-1:0]   ba_q;
    logic [COLWIDTH-1:0]  col_q;

    // Per-transaction terminal counts, chosen by direction
    logic [CNT_W-1:0]     pre_sel, end_sel, first_sel, last_sel;

    // Next values of the registered outputs
    logic                 cke_nxt, cs_n_nxt, act_n_nxt, odt_nxt, dq_oe_nxt;
    logic                 rd_valid_nxt, req_ready_nxt, busy_nxt;
    logic [ADDRWIDTH-1:0] a_nxt;
    logic [BGWIDTH-1:0]   bg_nxt;
    logic [BAWIDTH-1:0]   ba_nxt;

    // RD/WR command word: A16..A14 = RAS_n/CAS_n/WE_n, A12 = BL8, A10 = auto-precharge
    function automatic logic [ADDRWIDTH-1:0] cmd_addr(input logic wr,
                                                      input logic [COLWIDTH-1:0] col);
        logic [ADDRWIDTH-1:0] a;
        a               = '0;
        a[COLWIDTH-1:0] = col;
        a[12]           = 1'b1;
        a[10]           = AUTO_PRE;
        a[16]           = 1'b1;
        a[15]           = 1'b0;
        a[14]           = ~wr;
        return a;
    endfunction

    // PRE command word: RAS_n/CAS_n/WE_n = 0/1/0, A10=0 closes only the addressed bank
    function automatic logic [ADDRWIDTH-1:0] pre_addr();
        logic [ADDRWIDTH-1:0] a;
        a     = '0;
        a[15] = 1'b1;
        return a;
    endfunction

    assign accept    = (state == ST_IDLE) && req_valid && req_ready;
    assign cnt_inc   = (cnt >= C_CNT_MAX) ? cnt : cnt + CNT_W'(1);
    assign pre_sel   = wr_q ? C_PRE_WR   : C_PRE_RD;
    assign end_sel   = wr_q ? C_END_WR   : C_END_RD;
    assign first_sel = wr_q ? C_WR_FIRST : C_RD_FIRST;
    assign last_sel  = wr_q ? C_WR_LAST  : C_RD_LAST;

    // Next state and next transaction cycle count
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_inc;
        case (state)
            ST_INIT: begin
                if (cnt_inc >= C_TINIT) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            ST_IDLE: begin
                cnt_nxt = '0;
                if (accept) state_nxt = ST_ACT;
            end
            ST_ACT, ST_TRCD: begin
                state_nxt = (cnt_inc >= C_TRCD) ? ST_CMD : ST_TRCD;
            end
            ST_CMD, ST_DATA, ST_RECOVER: begin
                if (cnt_inc >= pre_sel)      state_nxt = ST_PRE;
                else if (cnt_inc > last_sel) state_nxt = ST_RECOVER;
                else                         state_nxt = ST_DATA;
            end
            ST_PRE, ST_TRP: begin
                if (cnt_inc >= end_sel) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = ST_TRP;
                end
            end
            default: begin
                state_nxt = ST_INIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state/cycle, so outputs register in step with it
    always_comb begin
        cke_nxt       = 1'b1;
        cs_n_nxt      = 1'b1;
        act_n_nxt     = 1'b1;
        a_nxt         = '0;
        bg_nxt        = bg;
        ba_nxt        = ba;
        odt_nxt       = 1'b0;
        dq_oe_nxt     = 1'b0;
        rd_valid_nxt  = 1'b0;
        req_ready_nxt = (state_nxt == ST_IDLE);
        busy_nxt      = (state_nxt != ST_IDLE);
        case (state_nxt)
            ST_INIT: cke_nxt = 1'b0;
            ST_ACT: begin
                // ACT is only entered on acceptance, so the live request is the source
                cs_n_nxt  = 1'b0;
                act_n_nxt = 1'b0;
                a_nxt     = req_row;
                bg_nxt    = req_bg;
                ba_nxt    = req_ba;
            end
            ST_CMD: begin
                cs_n_nxt = 1'b0;
                a_nxt    = cmd_addr(wr_q, col_q);
                bg_nxt   = bg_q;
                ba_nxt   = ba_q;
            end
            ST_DATA: begin
                if (cnt_nxt >= first_sel && cnt_nxt <= last_sel) begin
                    if (wr_q) begin
                        dq_oe_nxt = 1'b1;
                        odt_nxt   = 1'b1;
                    end else begin
                        rd_valid_nxt = 1'b1;
                    end
                end
            end
            ST_PRE: begin
                if (!AUTO_PRE) begin
                    cs_n_nxt = 1'b0;
                    a_nxt    = pre_addr();
                    bg_nxt   = bg_q;
                    ba_nxt   = ba_q;
                end
            end
            default: ;
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge ck_t) begin
        if (reset) begin
            state     <= ST_INIT;
            cnt       <= '0;
            cke       <= 1'b0;
            cs_n      <= 1'b1;
            act_n     <= 1'b1;
            A         <= '0;
            bg        <= '0;
            ba        <= '0;
            odt       <= 1'b0;
            dq_oe     <= 1'b0;
            rd_valid  <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            cke       <= cke_nxt;
            cs_n      <= cs_n_nxt;
            act_n     <= act_n_nxt;
            A         <= a_nxt;
            bg        <= bg_nxt;
            ba        <= ba_nxt;
            odt       <= odt_nxt;
            dq_oe     <= dq_oe_nxt;
            rd_valid  <= rd_valid_nxt;
            req_ready <= req_ready_nxt;
            busy      <= busy_nxt;
        end
    end

    // Request capture on acceptance; held for the whole transaction
    always_ff @(posedge ck_t) begin
        if (accept) begin
            wr_q  <= req_write;
            bg_q  <= req_bg;
            ba_q  <= req_ba;
            col_q <= req_col;
        end
    end

endmodule

// File: tb/tb_ddr4_cmd_sequencer.sv
// Directed bench for ddr4_cmd_sequencer with hand-computed cycle positions.
// Honours AUTO_PRECHARGE_EN the same way the design does.
module tb_ddr4_cmd_sequencer;

    logic        ck_t = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_bg;
    logic [1:0]  req_ba;
    logic [16:0] req_row;
    logic [9:0]  req_col;
    logic        cke, cs_n, act_n, odt, dq_oe, rd_valid, busy;
    logic [16:0] A;
    logic [1:0]  bg, ba;

    int errors = 0;
    int checks = 0;

`ifdef AUTO_PRECHARGE_EN
    localparam int AP_BIT  = 32'h400;
    localparam int PRE_A   = 0;
    localparam int PRE_CSN = 1;
`else
    localparam int AP_BIT  = 0;
    localparam int PRE_A   = 32'h8000;
    localparam int PRE_CSN = 0;
`endif

    ddr4_cmd_sequencer dut (
        .ck_t      (ck_t),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_bg    (req_bg),
        .req_ba    (req_ba),
        .req_row   (req_row),
        .req_col   (req_col),
        .cke       (cke),
        .cs_n      (cs_n),
        .act_n     (act_n),
        .A         (A),
        .bg        (bg),
        .ba        (ba),
        .odt       (odt),
        .dq_oe     (dq_oe),
        .rd_valid  (rd_valid),
        .busy      (busy)
    );

    always #5 ck_t = ~ck_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values();
        chk("rst cke", 32'(cke), 0);
        chk("rst cs_n", 32'(cs_n), 1);
        chk("rst act_n", 32'(act_n), 1);
        chk("rst A", 32'(A), 0);
        chk("rst bg", 32'(bg), 0);
        chk("rst ba", 32'(ba), 0);
        chk("rst odt", 32'(odt), 0);
        chk("rst dq_oe", 32'(dq_oe), 0);
        chk("rst rd_valid", 32'(rd_valid), 0);
        chk("rst req_ready", 32'(req_ready), 0);
        chk("rst busy", 32'(busy), 1);
    endtask

    // Called in the cycle right after reset is released; ends in the first IDLE cycle
    task automatic check_init();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("init%0d cke", i), 32'(cke), 0);
            chk($sformatf("init%0d cs_n", i), 32'(cs_n), 1);
            chk($sformatf("init%0d req_ready", i), 32'(req_ready), 0);
            @(negedge ck_t);
        end
        chk("init done cke", 32'(cke), 1);
        chk("init done req_ready", 32'(req_ready), 1);
        chk("init done busy", 32'(busy), 0);
        chk("init done cs_n", 32'(cs_n), 1);
    endtask

    // Entered in an IDLE cycle; returns in the IDLE cycle that ends the transaction,
    // or in cycle abort_c with reset driven high.
    task automatic run_txn(input logic wr, input logic [1:0] tbg, input logic [1:0] tba,
                           input logic [16:0] row, input logic [9:0] col, input logic hold,
                           input int abort_c, input int cmd_a, input int df, input int dl,
                           input int pre_c, input int end_c);
        int ea;
        int ecs;
        chk("txn start req_ready", 32'(req_ready), 1);
        req_write = wr;
        req_bg    = tbg;
        req_ba    = tba;
        req_row   = row;
        req_col   = col;
        req_valid = 1'b1;
        @(negedge ck_t);
        for (int c = 0; c <= end_c; c++) begin
            ecs = 1;
            ea  = 0;
            if (c == 0) begin
                ecs = 0;
                ea  = int'(row);
            end else if (c == 15) begin
                ecs = 0;
                ea  = cmd_a;
            end else if (c == pre_c) begin
                ecs = PRE_CSN;
                ea  = PRE_A;
            end
            chk($sformatf("c%0d cs_n", c), 32'(cs_n), 32'(ecs));
            chk($sformatf("c%0d act_n", c), 32'(act_n), (c == 0) ? 0 : 1);
            chk($sformatf("c%0d A", c), 32'(A), 32'(ea));
            chk($sformatf("c%0d bg", c), 32'(bg), 32'(tbg));
            chk($sformatf("c%0d ba", c), 32'(ba), 32'(tba));
            chk($sformatf("c%0d dq_oe", c), 32'(dq_oe), (wr && c >= df && c <= dl) ? 1 : 0);
            chk($sformatf("c%0d odt", c), 32'(odt), (wr && c >= df && c <= dl) ? 1 : 0);
            chk($sformatf("c%0d rd_valid", c), 32'(rd_valid), (!wr && c >= df && c <= dl) ? 1 : 0);
            chk($sformatf("c%0d req_ready", c), 32'(req_ready), (c == end_c) ? 1 : 0);
            chk($sformatf("c%0d busy", c), 32'(busy), (c == end_c) ? 0 : 1);
            chk($sformatf("c%0d cke", c), 32'(cke), 1);
            if (c == 0) begin
                // Scramble the request inputs; the sequencer must ignore them now
                req_valid = hold;
                req_write = ~wr;
                req_bg    = ~tbg;
                req_ba    = ~tba;
                req_row   = ~row;
                req_col   = ~col;
            end
            if (c == abort_c) begin
                reset = 1'b1;
                return;
            end
            if (c < end_c) @(negedge ck_t);
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_bg    = '0;
        req_ba    = '0;
        req_row   = '0;
        req_col   = '0;
        repeat (3) @(negedge ck_t);
        check_reset_values();
        reset = 1'b0;
        check_init();

        // Write bg=1 ba=1 row=1 col=0
        run_txn(1'b1, 2'd1, 2'd1, 17'd1, 10'd0, 1'b0, -1, 32'h11000 | AP_BIT, 27, 34, 47, 62);
        // Read, same address
        run_txn(1'b0, 2'd1, 2'd1, 17'd1, 10'd0, 1'b0, -1, 32'h15000 | AP_BIT, 30, 37, 38, 53);
        // Back-to-back: valid held high across the boundary
        run_txn(1'b0, 2'd2, 2'd3, 17'h1ABCD, 10'h3FF, 1'b1, -1, 32'h153FF | AP_BIT, 30, 37, 38, 53);
        run_txn(1'b1, 2'd0, 2'd2, 17'h00F0F, 10'h155, 1'b0, -1, 32'h11155 | AP_BIT, 27, 34, 47, 62);
        // Reset in cycle 20 of a write
        run_txn(1'b1, 2'd3, 2'd0, 17'h12345, 10'h02A, 1'b0, 20, 32'h1102A | AP_BIT, 27, 34, 47, 62);
        req_valid = 1'b0;
        @(negedge ck_t);
        check_reset_values();
        reset = 1'b0;
        check_init();
        // Normal operation after the abort
        run_txn(1'b0, 2'd1, 2'd2, 17'd2, 10'd8, 1'b0, -1, 32'h15008 | AP_BIT, 30, 37, 38, 53);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
